alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Adds full RV32I/RV64I integer ops, plus an optional iterative multiply/divide unit (RV M-subset).
- Uses a start/ready/valid handshake, so a multi-cycle datapath can stall on long operations.
- Sits between the register-file read stage and the writeback mux; ALU_Result_o and Zero_o keep their established meanings.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two ≥ 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from B_i[SHW-1:0]; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted only while ready_o=1.
- ALU_Operation_i  input  5  opcode, sampled at accept.
- A_i  input  WIDTH  operand A (signed view for signed ops), sampled at accept.
- B_i  input  WIDTH  operand B, sampled at accept.
- ready_o  output  1  1 = IDLE, can accept.
- valid_o  output  1  one-cycle pulse, result available.
- ALU_Result_o  output  WIDTH  registered result; held until next completion.
- Zero_o  output  1  registered; 1 when ALU_Result_o == 0.
- illegal_o  output  1  pulses with valid_o when the opcode is undefined/disabled.

Behaviour:
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 LUI (result=B).
  - 00011 AND, 00100 OR, 00101 XOR.
  - 00110 SLL, 00111 SRL, 01000 SRA.
  - 01001 SLT (signed), 01010 SLTU (result 0/1, zero-extended).
  - 10000 MUL (low WIDTH), 10001 MULHU (high WIDTH, unsigned).
  - 10010 DIV, 10011 DIVU, 10100 REM, 10101 REMU.
  - All others illegal: result 0, illegal_o=1, latency 1.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no carry/overflow output. Shifts use B_i[SHW-1:0] only.
- Reset (reset=0, async): state IDLE, ready_o=1, valid_o=0, ALU_Result_o=0, Zero_o=1, illegal_o=0. Any in-flight operation is discarded, with no completion pulse.
- FSM states:
  - IDLE: ready_o=1.
    - start_i=1 with a simple/illegal op → compute and register the result → DONE.
    - start_i=1 with an MDU op → latch operands, clear counter → BUSY.
  - BUSY: ready_o=0. One radix-2 step per cycle.
    - Shift-add multiply on a 2*WIDTH accumulator; restoring divide on magnitudes.
    - Counter runs 0..WIDTH-1; at WIDTH-1, write the result (sign-corrected for DIV/REM) → DONE.
  - DONE: ready_o=0, valid_o=1 for exactly this cycle → IDLE.
- Latency from accept to valid_o: simple ops 1 cycle; MDU ops WIDTH+1 cycles. Next accept is possible the cycle after valid_o.
- Throughput: one op per 2 cycles for simple ops.
- start_i while ready_o=0 is ignored, not queued. Operand/opcode changes after accept have no effect.
- Divide corner cases (RISC-V semantics, no exception):
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU remainder = A.
  - Signed overflow (A = most-negative, B = -1): DIV = A, REM = 0.
  - Both corner cases complete in 1 cycle via the simple-op path.
- REM sign follows the dividend; DIV truncates toward zero.
- Zero_o and ALU_Result_o update on the same edge, only on completion.

Optional Feature:
- Macro: ALU_MC_MDU_EN.
- Defined: multiply/divide opcodes 10000–10101 are executed as above.
- Undefined: the MDU datapath and BUSY state are not compiled. Those opcodes take the illegal path: result 0, Zero_o=1, illegal_o=1, latency 1. All other behaviour is identical.

Test Plan:
- Reset mid-DIVU (assert reset at BUSY cycle 10) → immediately ready_o=1, ALU_Result_o=0, Zero_o=1; no valid_o for the killed op.
- ADD A=0x7FFFFFFF, B=1 → valid_o 1 cycle after accept, result 0x80000000, Zero_o=0. SUB 5-5 → result 0, Zero_o=1. LUI B=0x12345000 → 0x12345000.
- SRA A=0x80000000, B=0x00000024 (shamt 4) → 0xF8000000. SLTU A=1, B=0xFFFFFFFF → 1. SLT with the same operands → 0.
- MUL A=0xFFFFFFFF, B=0xFFFFFFFF → low 0x00000001 after 33 cycles. MULHU with the same operands → 0xFFFFFFFE. start_i pulses during BUSY are ignored.
- DIV A=-7, B=2 → -3; REM → -1. DIVU A=7, B=0 → 0xFFFFFFFF; REMU → 7. DIV A=0x80000000, B=-1 → 0x80000000; REM → 0.
- Opcode 11111, and (with ALU_MC_MDU_EN undefined) opcode 10000 → result 0, Zero_o=1, illegal_o pulses with valid_o after 1 cycle.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with start/ready/valid handshake.
// Simple ops complete one cycle after accept; the optional iterative
// multiply/divide unit (compiled only when ALU_MC_MDU_EN is defined)
// runs one radix-2 step per cycle for WIDTH cycles.
//
// state | meaning
// IDLE  | ready_o=1, waiting for start_i
// BUSY  | iterating multiply/divide (only with ALU_MC_MDU_EN)
// DONE  | result registered, valid_o=1 for this single cycle
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [4:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o,
  output logic             illegal_o
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_LUI   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRL   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
`ifdef ALU_MC_MDU_EN
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_REM   = 5'b10100;
  localparam logic [4:0] OP_REMU  = 5'b10101;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MC_MDU_EN
    ST_BUSY = 2'd2,
`endif
    ST_DONE = 2'd1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ill_q;

  logic [WIDTH-1:0] simple_res;
  logic             simple_ill;
  logic             is_mdu;
  logic [SHW-1:0]   shamt;

  assign shamt = B_i[SHW-1:0];

`ifdef ALU_MC_MDU_EN
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [SHW-1:0]     cnt_q;
  logic [4:0]         op_q;
  logic               neg_quo_q;
  logic               neg_rem_q;

  logic               div_signed;
  logic               is_div_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   mdu_res;
`endif

  // Single-cycle results, plus detection of ops that must go to the MDU.
  always_comb begin
    simple_res = '0;
    simple_ill = 1'b0;
    is_mdu     = 1'b0;
    case (ALU_Operation_i)
      OP_ADD:  simple_res = A_i + B_i;
      OP_SUB:  simple_res = A_i - B_i;
      OP_LUI:  simple_res = B_i;
      OP_AND:  simple_res = A_i & B_i;
      OP_OR:   simple_res = A_i | B_i;
      OP_XOR:  simple_res = A_i ^ B_i;
      OP_SLL:  simple_res = A_i << shamt;
      OP_SRL:  simple_res = A_i >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(A_i) >>> shamt);
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (A_i < B_i)};
`ifdef ALU_MC_MDU_EN
      OP_MUL, OP_MULHU: is_mdu = 1'b1;
      // Divide-by-zero and signed overflow resolve here without iterating.
      OP_DIV: begin
        if (B_i == '0)                          simple_res = '1;
        else if (A_i == MOST_NEG && B_i == '1)  simple_res = A_i;
        else                                    is_mdu = 1'b1;
      end
      OP_DIVU: begin
        if (B_i == '0) simple_res = '1;
        else           is_mdu = 1'b1;
      end
      OP_REM: begin
        if (B_i == '0)                          simple_res = A_i;
        else if (A_i == MOST_NEG && B_i == '1)  simple_res = '0;
        else                                    is_mdu = 1'b1;
      end
      OP_REMU: begin
        if (B_i == '0) simple_res = A_i;
        else           is_mdu = 1'b1;
      end
`endif
      default: simple_ill = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
`ifdef ALU_MC_MDU_EN
          if (is_mdu) state_d = ST_BUSY;
          else        state_d = ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef ALU_MC_MDU_EN
      ST_BUSY: if (cnt_q == CNT_LAST) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_MC_MDU_EN
  assign div_signed = (ALU_Operation_i == OP_DIV) || (ALU_Operation_i == OP_REM);
  assign a_mag      = (div_signed && A_i[WIDTH-1]) ? -A_i : A_i;
  assign b_mag      = (div_signed && B_i[WIDTH-1]) ? -B_i : B_i;
  assign is_div_q   = (op_q != OP_MUL) && (op_q != OP_MULHU);

  // One radix-2 step: shift-add multiply or restoring divide on acc_q.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, opb_q};
    q_bit     = ~rem_diff[WIDTH];
    rem_new   = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    step_next = is_div_q ? {rem_new, acc_q[WIDTH-2:0], q_bit}
                         : {mul_sum, acc_q[WIDTH-1:1]};
    case (op_q)
      OP_MUL:           mdu_res = step_next[WIDTH-1:0];
      OP_MULHU:         mdu_res = step_next[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:  mdu_res = neg_quo_q ? -step_next[WIDTH-1:0]
                                            : step_next[WIDTH-1:0];
      default:          mdu_res = neg_rem_q ? -step_next[2*WIDTH-1:WIDTH]
                                            : step_next[2*WIDTH-1:WIDTH];
    endcase
  end

  // MDU operand latch at accept, then one step per BUSY cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == ST_IDLE && start_i && is_mdu) begin
      acc_q     <= {{WIDTH{1'b0}}, a_mag};
      opb_q     <= b_mag;
      cnt_q     <= '0;
      op_q      <= ALU_Operation_i;
      neg_quo_q <= div_signed && (A_i[WIDTH-1] ^ B_i[WIDTH-1]);
      neg_rem_q <= div_signed && A_i[WIDTH-1];
    end else if (state_q == ST_BUSY) begin
      acc_q <= step_next;
      cnt_q <= cnt_q + CNT_ONE;
    end
  end
`endif

  // Result, zero and illegal flags change only on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ill_q    <= 1'b0;
    end else if (state_q == ST_IDLE && start_i && !is_mdu) begin
      result_q <= simple_res;
      zero_q   <= (simple_res == '0);
      ill_q    <= simple_ill;
    end
`ifdef ALU_MC_MDU_EN
    else if (state_q == ST_BUSY && cnt_q == CNT_LAST) begin
      result_q <= mdu_res;
      zero_q   <= (mdu_res == '0);
      ill_q    <= 1'b0;
    end
`endif
  end

  assign ready_o      = (state_q == ST_IDLE);
  assign valid_o      = (state_q == ST_DONE);
  assign illegal_o    = (state_q == ST_DONE) && ill_q;
  assign ALU_Result_o = result_q;
  assign Zero_o       = zero_q;

endmodule
